// File: rtl/gate_test_pkg.sv
// Shared types and truth-table constants for the 2-input gate stimulus sequencer.
`timescale 1ns/1ps
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef logic [1:0] vec_idx_t;

    localparam logic [3:0] XOR_TT = 4'b0110;
    localparam logic [3:0] AND_TT = 4'b1000;
    localparam logic [3:0] OR_TT  = 4'b1110;

endpackage

// File: rtl/gate_settle_timer.sv
// Loadable down-counter; o_expire is high during the last cycle of a loaded interval.
`timescale 1ns/1ps
module gate_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    // Counter: load wins, otherwise count down to zero and rest there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/gate_tt_sequencer.sv
// Clocked, restartable sweep of a 2-input gate: drives a/b, samples y after a settle
// time, builds the observed truth table and compares it against EXP_TT.
`timescale 1ns/1ps
module gate_tt_sequencer
    import gate_test_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter int         NUM_PASSES    = 1,
    parameter logic [3:0] EXP_TT        = 4'b0110,
    parameter int         CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       tt,
    output logic [3:0]       err_vec,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int TW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [PW-1:0]    LAST_PASS = PW'(NUM_PASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    // With no settle time every vector goes straight to its capture cycle.
    localparam state_t HOLD_STATE = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;

    state_t           r_state;
    vec_idx_t         r_idx;
    logic [PW-1:0]    r_pass_idx;
    logic             r_a, r_b, r_busy, r_done, r_pass;
    logic [3:0]       r_tt, r_err_vec;
    logic [CNT_W-1:0] r_err_cnt;

    logic w_start_ok, w_mismatch, w_final, w_load, w_expire;

    // Decode start acceptance, mismatch and timer reload for the current cycle.
    always_comb begin
        w_start_ok = 1'b0;
        w_load     = 1'b0;
        w_mismatch = (y != EXP_TT[r_idx]);
        w_final    = (r_idx == 2'd3) && (r_pass_idx == LAST_PASS);
        if ((r_state == IDLE) || (r_state == DONE)) begin
            w_start_ok = start;
            w_load     = start;
        end else if (r_state == CAPTURE) begin
            w_load = !w_final;
        end else begin
            w_load = 1'b0;
        end
    end

    gate_settle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (TW'(SETTLE_CYCLES)),
        .o_expire   (w_expire)
    );

    // Sequencer FSM with capture/compare; all outputs come straight from these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= 2'd0;
            r_pass_idx <= '0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_tt       <= 4'd0;
            r_err_vec  <= 4'd0;
            r_err_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_tt       <= 4'd0;
                        r_err_vec  <= 4'd0;
                        r_err_cnt  <= '0;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_idx      <= 2'd0;
                        r_pass_idx <= '0;
                        r_a        <= 1'b0;
                        r_b        <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= HOLD_STATE;
                    end else begin
                        r_state <= r_state;
                    end
                end
                SETTLE: begin
                    if (w_expire) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_state <= SETTLE;
                    end
                end
                CAPTURE: begin
                    r_tt[r_idx] <= y;
                    if (w_mismatch) begin
                        r_err_vec[r_idx] <= 1'b1;
                        if (r_err_cnt != CNT_MAX) begin
                            r_err_cnt <= r_err_cnt + CNT_W'(1);
                        end else begin
                            r_err_cnt <= r_err_cnt;
                        end
                    end else begin
                        r_err_cnt <= r_err_cnt;
                    end
                    if (r_idx != 2'd3) begin
                        r_idx        <= r_idx + 2'd1;
                        {r_a, r_b}   <= r_idx + 2'd1;
                        r_state      <= HOLD_STATE;
                    end else if (!w_final) begin
                        r_pass_idx <= r_pass_idx + PW'(1);
                        r_idx      <= 2'd0;
                        r_a        <= 1'b0;
                        r_b        <= 1'b0;
                        r_state    <= HOLD_STATE;
                    end else begin
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_vec == 4'd0) && !w_mismatch;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign a       = r_a;
    assign b       = r_b;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign tt      = r_tt;
    assign err_vec = r_err_vec;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench: several sequencer configurations against modelled gates, results via scoreboard.
`timescale 1ns/1ps
module tb_gate_tt_sequencer;
    import gate_test_pkg::*;

    typedef struct {
        logic [3:0] tt;
        logic [3:0] ev;
        logic [7:0] cnt;
        logic       pass;
        int         lat;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [4:0]      st;
    logic [4:0]      a_w, b_w, busy_w, done_w, pass_w, y_w;
    logic [4:0][3:0] tt_w, ev_w;
    logic [4:0][7:0] cnt_w;
    logic [1:0]      cnt3;
    int              ymode0;
    int              errors = 0;
    int              checks = 0;

    // Gate models: instance 0 is switchable (0: xor, 1: stuck-at-0, 2: and).
    assign y_w[0] = (ymode0 == 0) ? (a_w[0] ^ b_w[0]) :
                    (ymode0 == 1) ? 1'b0 : (a_w[0] & b_w[0]);
    assign y_w[1] = a_w[1] & b_w[1];
    assign y_w[2] = 1'b0;
    assign y_w[3] = 1'b0;
    assign y_w[4] = a_w[4] ^ b_w[4];
    assign cnt_w[3] = {6'd0, cnt3};

    gate_tt_sequencer #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .EXP_TT(XOR_TT), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .y(y_w[0]), .a(a_w[0]), .b(b_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .tt(tt_w[0]),
        .err_vec(ev_w[0]), .err_cnt(cnt_w[0]));
    gate_tt_sequencer #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .EXP_TT(AND_TT), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .y(y_w[1]), .a(a_w[1]), .b(b_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .tt(tt_w[1]),
        .err_vec(ev_w[1]), .err_cnt(cnt_w[1]));
    gate_tt_sequencer #(.SETTLE_CYCLES(2), .NUM_PASSES(3), .EXP_TT(XOR_TT), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .y(y_w[2]), .a(a_w[2]), .b(b_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .tt(tt_w[2]),
        .err_vec(ev_w[2]), .err_cnt(cnt_w[2]));
    gate_tt_sequencer #(.SETTLE_CYCLES(2), .NUM_PASSES(3), .EXP_TT(XOR_TT), .CNT_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .y(y_w[3]), .a(a_w[3]), .b(b_w[3]),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .tt(tt_w[3]),
        .err_vec(ev_w[3]), .err_cnt(cnt3));
    gate_tt_sequencer #(.SETTLE_CYCLES(0), .NUM_PASSES(1), .EXP_TT(XOR_TT), .CNT_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[4]), .y(y_w[4]), .a(a_w[4]), .b(b_w[4]),
        .busy(busy_w[4]), .done(done_w[4]), .pass(pass_w[4]), .tt(tt_w[4]),
        .err_vec(ev_w[4]), .err_cnt(cnt_w[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run on instance k: hold time S, optional re-pulse of start at cycle `repulse`.
    task automatic run(input int k, input int S, input exp_t e, input int repulse);
        int   cyc;
        logic seen;
        exp_t r;
        sb.push_back(e);
        @(negedge clk);
        st[k] = 1'b1;
        @(posedge clk);
        #1;
        st[k] = 1'b0;
        chk("busy_rise", busy_w[k], 32'd1);
        chk("done_clr", done_w[k], 32'd0);
        chk("first_vec", {a_w[k], b_w[k]}, 32'd0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            st[k] = (cyc == repulse) ? 1'b1 : 1'b0;
            seen  = done_w[k];
            if (!seen) chk("vec_ab", {a_w[k], b_w[k]}, (cyc / (S + 1)) % 4);
        end
        st[k] = 1'b0;
        r = sb.pop_front();
        chk("timeout", seen, 32'd1);
        chk("latency", cyc, r.lat);
        chk("tt", tt_w[k], r.tt);
        chk("err_vec", ev_w[k], r.ev);
        chk("err_cnt", cnt_w[k], r.cnt);
        chk("pass", pass_w[k], r.pass);
        chk("busy_end", busy_w[k], 32'd0);
        chk("ab_end", {a_w[k], b_w[k]}, 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        st     = 5'd0;
        ymode0 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0]}, 32'd0);
        chk("rst_regs", {tt_w[0], ev_w[0], cnt_w[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 2, exp_t'{4'b0110, 4'b0000, 8'd0, 1'b1, 12}, 0);
        ymode0 = 1;
        run(0, 2, exp_t'{4'b0000, 4'b0110, 8'd2, 1'b0, 12}, 0);
        ymode0 = 2;
        run(0, 2, exp_t'{4'b1000, 4'b1110, 8'd3, 1'b0, 12}, 0);
        run(1, 2, exp_t'{4'b1000, 4'b0000, 8'd0, 1'b1, 12}, 0);
        run(2, 2, exp_t'{4'b0000, 4'b0110, 8'd6, 1'b0, 36}, 0);
        run(3, 2, exp_t'{4'b0000, 4'b0110, 8'd3, 1'b0, 36}, 0);
        ymode0 = 0;
        run(0, 2, exp_t'{4'b0110, 4'b0000, 8'd0, 1'b1, 12}, 5);

        // Reset asserted mid-run while vector 10 is on the pins.
        @(negedge clk);
        st[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre_rst_vec", {a_w[0], b_w[0]}, 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0]}, 32'd0);
        chk("mid_rst_regs", {tt_w[0], ev_w[0], cnt_w[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 2, exp_t'{4'b0110, 4'b0000, 8'd0, 1'b1, 12}, 0);

        run(4, 0, exp_t'{4'b0110, 4'b0000, 8'd0, 1'b1, 4}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
